// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator driven by one shared period counter.
// Each channel has a double-buffered duty (shadow -> active) so that duty
// changes only take effect at a period boundary and never glitch an output.
// Optional build macro: PWM_PHASE_STAGGER_EN staggers each channel's phase by
// i*(PERIOD/CHANNELS) clocks, so rising edges spread across the period; each
// channel then reloads its duty at its own phase wrap.
module pwm_bank #(
  parameter int  CHANNELS = 3,
  parameter int  PERIOD   = 10000,
  parameter bit  OUT_INV  = 1'b0,
  localparam int CNT_W    = $clog2(PERIOD + 1),
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_wr_en,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [CNT_W-1:0]    i_wr_duty,
  output logic [CHANNELS-1:0] o_pwm_out,
  output logic                o_period_tick
);

  localparam logic [CNT_W-1:0]    LAST     = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]    PERIOD_V = CNT_W'(PERIOD);
  localparam logic [CHANNELS-1:0] IDLE     = {CHANNELS{OUT_INV}};

  logic [CNT_W-1:0]                 r_cnt;
  logic [CHANNELS-1:0][CNT_W-1:0]   r_shadow;
  logic [CHANNELS-1:0][CNT_W-1:0]   r_active;
  logic [CHANNELS-1:0]              r_pwmOut;
  logic                             r_periodTick;

  logic [CHANNELS-1:0][CNT_W-1:0]   w_shadowNext;
  logic [CHANNELS-1:0][CNT_W-1:0]   w_phase;
  logic [CHANNELS-1:0]              w_load;
  logic [CHANNELS-1:0]              w_level;
  logic [CNT_W-1:0]                 w_wrDutySat;
  logic                             w_cntWrap;

  // Duties longer than a full period are clamped to "always on".
  assign w_wrDutySat = (i_wr_duty > PERIOD_V) ? PERIOD_V : i_wr_duty;

  // The shared counter wraps only while running.
  assign w_cntWrap = i_en && (r_cnt == LAST);

  // Shadow value as it will be after this edge, so a same-cycle write is seen by the load.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_shadowNext[i] = r_shadow[i];
      if (i_wr_en && (int'(i_wr_ch) == i)) begin
        w_shadowNext[i] = w_wrDutySat;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
`ifdef PWM_PHASE_STAGGER_EN
    localparam int               PW     = CNT_W + 1;
    localparam logic [CNT_W:0]   OFF_G  = PW'((g * (PERIOD / CHANNELS)) % PERIOD);
    localparam logic [CNT_W:0]   PER_W  = PW'(PERIOD);
    logic [CNT_W:0] w_sum;

    // Both terms are below PERIOD, so one conditional subtract gives the modulo.
    assign w_sum        = {1'b0, r_cnt} + OFF_G;
    assign w_phase[g]   = (w_sum >= PER_W) ? CNT_W'(w_sum - PER_W) : w_sum[CNT_W-1:0];
    assign w_load[g]    = i_en && (w_phase[g] == LAST);
`else
    assign w_phase[g]   = r_cnt;
    assign w_load[g]    = w_cntWrap;
`endif
    assign w_level[g]   = (w_phase[g] < r_active[g]);
  end

  // Shared period counter: held at zero while disabled, wraps at PERIOD-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_cntWrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow duty registers capture host writes immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= w_shadowNext;
    end
  end

  // Active duties follow the shadow at each channel's boundary, or continuously while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!i_en || w_load[i]) begin
          r_active[i] <= w_shadowNext[i];
        end
      end
    end
  end

  // Registered outputs: compare result one clock late, idle level while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwmOut     <= IDLE;
      r_periodTick <= 1'b0;
    end else begin
      r_periodTick <= w_cntWrap;
      if (i_en) begin
        r_pwmOut <= w_level ^ IDLE;
      end else begin
        r_pwmOut <= IDLE;
      end
    end
  end

  assign o_pwm_out     = r_pwmOut;
  assign o_period_tick = r_periodTick;

endmodule
